// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter state and the data word.
package cpu_types_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned STREAK_W  = 4;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while an instruction fetch waits.
module arb_streak_ctr
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    logic [STREAK_W-1:0] r_count;

    assign o_sat = (r_count == STREAK_W'(MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + STREAK_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache accesses onto one single-port RAM,
// bounding data grants in a row while an instruction fetch is pending.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    arb_state_t r_state;
    ramstate_t  w_rs;
    logic       w_dreq;
    logic       w_sat;
    logic       w_go_d;
    logic       w_go_i;
    logic       w_ihold;
    logic       w_dhold;
    logic       w_exit;

    assign w_rs   = ramstate_t'(ramstate);
    assign w_dreq = dREN | dWEN;

    // Data wins unless it has used up its streak while an instruction fetch waits.
    assign w_go_d = (r_state == IDLE) && w_dreq && (!w_sat || !iREN);
    assign w_go_i = (r_state == IDLE) && !w_go_d && iREN;

    assign w_ihold = (r_state == IGRANT) && iREN;
    assign w_dhold = (r_state == DGRANT) && w_dreq;
    assign w_exit  = (r_state != IDLE) &&
                     (!(w_ihold || w_dhold) || (w_rs == ACCESS) || (w_rs == ERROR));

    arb_streak_ctr #(
        .MAX (MAX_DSTREAK)
    ) u_streak (
        .CLK   (CLK),
        .nRST  (nRST),
        .i_inc (w_go_d && iREN),
        .i_clr (w_go_i || ((r_state == IDLE) && !iREN)),
        .o_sat (w_sat)
    );

    // A withdrawn request gets no completion pulse even if the RAM finishes.
    assign iwait = !(w_ihold && (w_rs == ACCESS));
    assign dwait = !(w_dhold && (w_rs == ACCESS));
    assign iload = (r_state == IGRANT) ? ramload : '0;
    assign dload = (r_state == DGRANT) ? ramload : '0;
    assign err   = (r_state != IDLE) && (w_rs == ERROR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go_d) begin
                        r_state  <= DGRANT;
                        ramWEN   <= dWEN;
                        ramREN   <= dREN & ~dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                    end else if (w_go_i) begin
                        r_state <= IGRANT;
                        ramREN  <= 1'b1;
                        ramaddr <= iaddr;
                    end
                end
                default: begin
                    if (w_exit) begin
                        r_state  <= IDLE;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, data/instr contention, streak limit,
// RAM error retry, fetch withdrawal and reset during a write.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int n_total;
    int n_pass;
    byte order_q[$];
    byte exp_order[6];

    mem_arbiter #(
        .ADDR_W      (32),
        .WORD_W      (32),
        .MAX_DSTREAK (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        CLK      = 1'b0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = 32'hAAAA_5555;
        ramstate = FREE;
        exp_order = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};

        // Reset values
        #2;
        chk("rst_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        chk("rst_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        chk("rst_err", err === 1'b0, 64'(err), 64'(1'b0));
        chk("rst_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        chk("rst_ramWEN", ramWEN === 1'b0, 64'(ramWEN), 64'(1'b0));
        chk("rst_ramaddr", ramaddr === 32'h0, 64'(ramaddr), 64'(32'h0));
        chk("rst_ramstore", ramstore === 32'h0, 64'(ramstore), 64'(32'h0));
        chk("rst_iload", iload === 32'h0, 64'(iload), 64'(32'h0));
        chk("rst_dload", dload === 32'h0, 64'(dload), 64'(32'h0));
        next();
        nRST = 1'b1;
        next();

        // Single fetch: two BUSY cycles then ACCESS
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hDEAD_BEEF;
        #1;
        chk("t1_c0_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        next();
        #1;
        chk("t1_c1_ramREN", ramREN === 1'b1, 64'(ramREN), 64'(1'b1));
        chk("t1_c1_ramaddr", ramaddr === 32'h40, 64'(ramaddr), 64'(32'h40));
        chk("t1_c1_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        next();
        #1;
        chk("t1_c2_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        next();
        ramstate = ACCESS;
        #1;
        chk("t1_c3_iwait", iwait === 1'b0, 64'(iwait), 64'(1'b0));
        chk("t1_c3_iload", iload === 32'hDEAD_BEEF, 64'(iload), 64'(32'hDEAD_BEEF));
        chk("t1_c3_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        chk("t1_c3_dload", dload === 32'h0, 64'(dload), 64'(32'h0));
        next();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk("t1_c4_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        chk("t1_c4_ramaddr", ramaddr === 32'h0, 64'(ramaddr), 64'(32'h0));
        chk("t1_c4_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        chk("t1_c4_iload", iload === 32'h0, 64'(iload), 64'(32'h0));
        next();

        // Simultaneous fetch and write: data first, then instruction
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        ramstate = BUSY;
        next();
        #1;
        chk("t2_d_ramWEN", ramWEN === 1'b1, 64'(ramWEN), 64'(1'b1));
        chk("t2_d_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        chk("t2_d_ramaddr", ramaddr === 32'h80, 64'(ramaddr), 64'(32'h80));
        chk("t2_d_ramstore", ramstore === 32'h1234, 64'(ramstore), 64'(32'h1234));
        chk("t2_d_dwait_busy", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        ramstate = ACCESS;
        #1;
        chk("t2_d_dwait_done", dwait === 1'b0, 64'(dwait), 64'(1'b0));
        chk("t2_d_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        next();
        dWEN = 1'b0; ramstate = BUSY;
        #1;
        chk("t2_idle_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        chk("t2_idle_ramWEN", ramWEN === 1'b0, 64'(ramWEN), 64'(1'b0));
        next();
        #1;
        chk("t2_i_ramREN", ramREN === 1'b1, 64'(ramREN), 64'(1'b1));
        chk("t2_i_ramaddr", ramaddr === 32'h44, 64'(ramaddr), 64'(32'h44));
        ramstate = ACCESS;
        #1;
        chk("t2_i_iwait", iwait === 1'b0, 64'(iwait), 64'(1'b0));
        chk("t2_i_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        next();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk("t2_end_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        chk("t2_end_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        next();

        // Continuous data reads against a pending fetch: streak limit of 4
        dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h200; ramstate = ACCESS;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (!dwait) order_q.push_back(8'h44);
            if (!iwait) order_q.push_back(8'h49);
            next();
        end
        dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
        chk("t3_count", order_q.size() === 6, 64'(order_q.size()), 64'(6));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_order%0d", k), order_q[k] === exp_order[k],
                64'(order_q[k]), 64'(exp_order[k]));
        end
        next();

        // RAM error on a data read: err pulse, retry after one idle cycle
        dREN = 1'b1; daddr = 32'h300; ramstate = ERROR;
        #1;
        chk("t4_idle_err", err === 1'b0, 64'(err), 64'(1'b0));
        next();
        #1;
        chk("t4_g_ramREN", ramREN === 1'b1, 64'(ramREN), 64'(1'b1));
        chk("t4_g_err", err === 1'b1, 64'(err), 64'(1'b1));
        chk("t4_g_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        next();
        #1;
        chk("t4_idle2_err", err === 1'b0, 64'(err), 64'(1'b0));
        chk("t4_idle2_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        chk("t4_idle2_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        ramstate = ACCESS;
        next();
        #1;
        chk("t4_retry_ramREN", ramREN === 1'b1, 64'(ramREN), 64'(1'b1));
        chk("t4_retry_ramaddr", ramaddr === 32'h300, 64'(ramaddr), 64'(32'h300));
        chk("t4_retry_dwait", dwait === 1'b0, 64'(dwait), 64'(1'b0));
        next();
        dREN = 1'b0; ramstate = FREE;
        next();

        // Fetch withdrawn while RAM is busy
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
        next();
        #1;
        chk("t5_g_ramREN", ramREN === 1'b1, 64'(ramREN), 64'(1'b1));
        iREN = 1'b0;
        #1;
        chk("t5_g_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        next();
        ramstate = ACCESS;
        #1;
        chk("t5_ab_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        chk("t5_ab_iwait", iwait === 1'b1, 64'(iwait), 64'(1'b1));
        next();
        #1;
        chk("t5_idle_ramREN", ramREN === 1'b0, 64'(ramREN), 64'(1'b0));
        ramstate = FREE;
        next();

        // Reset asserted during a write grant
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'h77; ramstate = BUSY;
        next();
        #1;
        chk("t6_g_ramWEN", ramWEN === 1'b1, 64'(ramWEN), 64'(1'b1));
        #2;
        nRST = 1'b0;
        ramstate = ACCESS;
        #1;
        chk("t6_rst_ramWEN", ramWEN === 1'b0, 64'(ramWEN), 64'(1'b0));
        chk("t6_rst_ramaddr", ramaddr === 32'h0, 64'(ramaddr), 64'(32'h0));
        chk("t6_rst_ramstore", ramstore === 32'h0, 64'(ramstore), 64'(32'h0));
        chk("t6_rst_dwait", dwait === 1'b1, 64'(dwait), 64'(1'b1));
        next();
        nRST = 1'b1;
        next();
        #1;
        chk("t6_after_ramWEN", ramWEN === 1'b1, 64'(ramWEN), 64'(1'b1));
        chk("t6_after_ramaddr", ramaddr === 32'h600, 64'(ramaddr), 64'(32'h600));
        chk("t6_after_dwait", dwait === 1'b0, 64'(dwait), 64'(1'b0));
        next();
        dWEN = 1'b0; ramstate = FREE;
        #1;
        chk("t6_end_ramWEN", ramWEN === 1'b0, 64'(ramWEN), 64'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache, in front of the single-port RAM.
- Arbitrates between the icache fill channel (iREN/iaddr) and the dcache channel (dREN/dWEN/daddr/dstore).
- Grants one requester at a time and forwards its access to RAM.
- Returns load data and a completion handshake (iwait/dwait low) to the granted cache only.

Parameters:
- ADDR_W, 32, width of all address buses.
- WORD_W, 32, width of all data buses.
- MAX_DSTREAK, 4, consecutive data grants allowed while iREN is pending before instruction is forced (1..15).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iload  out  WORD_W  read data to icache
- iwait  out  1  low for exactly one cycle when the icache access completes
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  WORD_W  dcache write data
- dload  out  WORD_W  read data to dcache
- dwait  out  1  low for exactly one cycle when the dcache access completes
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  one-cycle pulse on RAM ERROR

Behaviour:
- Reset values (async):
  - State IDLE; streak counter 0.
  - iwait=1, dwait=1, err=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0; iload=0, dload=0.
- States: IDLE, IGRANT, DGRANT.
- IDLE transitions:
  - Data request (dREN|dWEN) and (streak<MAX_DSTREAK or !iREN) -> DGRANT.
  - Otherwise iREN -> IGRANT.
  - Otherwise stay in IDLE.
- Streak counter:
  - Increments on entry to DGRANT while iREN=1.
  - Clears on entry to IGRANT, or when iREN=0 in IDLE.
  - Saturates at MAX_DSTREAK.
- RAM outputs are registered, loaded on the edge entering a grant state:
  - IGRANT: ramREN=1, ramaddr=iaddr.
  - DGRANT: ramWEN=dWEN, ramREN=dREN&!dWEN (write wins if both asserted), ramaddr=daddr, ramstore=dstore.
  - Outputs are held for the whole grant and cleared to 0 on return to IDLE.
- Completion:
  - In a grant state with ramstate==ACCESS, the granted wait goes low combinationally for that cycle.
  - iload/dload = ramload, passed through only for the granted side (0 otherwise).
  - State -> IDLE on the next edge.
- Latency: request seen in IDLE at cycle N -> RAM driven from N+1 -> earliest completion at N+1. Minimum 2 cycles per access; back-to-back accesses need one IDLE cycle between them.
- Stall: ramstate BUSY or FREE holds the grant with wait high, indefinitely.
- Error: ramstate==ERROR in a grant state gives err=1 for one cycle, wait stays high, state -> IDLE, and the request is re-arbitrated.
- Request withdrawn while granted (granted REN/WEN deasserted): abort to IDLE on the next edge with no wait pulse; the RAM enables drop on the same edge.
- The non-granted wait stays high at all times.
- Reset mid-access: immediate return to reset values; the RAM transaction is abandoned.

Decomposition:
- Shared package cpu_types_pkg holds:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - arb_state_t enum (IDLE, IGRANT, DGRANT).
  - word_t.
- Sub-module arb_streak_ctr: saturating streak counter with inc/clr/sat outputs. Everything else stays flat.

Test Plan:
- iREN=1, iaddr=0x40 alone; RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 from cycle 1; iwait low only in cycle 3 with iload=0xDEADBEEF; ramREN=0 at cycle 4.
- iREN and dWEN both asserted in the same cycle, daddr=0x80, dstore=0x1234 -> DGRANT first: ramWEN=1, ramstore=0x1234, dwait pulses once; then IGRANT, iwait pulses once.
- dREN held continuously with iREN pending, MAX_DSTREAK=4 -> exactly 4 data completions, then 1 instruction completion, then data resumes.
- Granted data access gets ramstate=ERROR -> err=1 for one cycle, dwait stays high, DGRANT re-entered after one IDLE cycle.
- iREN dropped during IGRANT while BUSY -> ramREN=0 on the next edge, iwait never goes low, state IDLE.
- nRST asserted during DGRANT with ramWEN=1 -> ramWEN=0, dwait=1, state IDLE immediately; normal operation after release.
